ex_stage: RTL and testbench

- Execute stage placed directly downstream of the ID/EX pipeline register.
- Consumes operand A/B, opcode, immediate, destination register and register-write flag.
- Computes ALU results and memory addresses, keeps the CMP condition flags, and drives the EX/MEM pipeline register.
- MUL and DIV are iterative (16 cycles). During them the block stalls upstream through `stall_out`.

---
 rtl/ex_stage.sv | 208 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, address generation and CMP flags, plus
// iterative 16-step MUL/DIV that stalls upstream while it runs.
module ex_stage #(
  parameter int WIDTH     = 16,
  parameter int MD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [7:0]       opcode_in,
  input  logic [WIDTH-1:0] imedi_in,
  input  logic [3:0]       destreg_in,
  input  logic             set_regwrite_in,
  output logic             stall_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] addr_out,
  output logic [WIDTH-1:0] store_data_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [3:0]       destreg_out,
  output logic             set_regwrite_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  localparam logic [7:0] OP_NOT = 8'h2A;
  localparam logic [7:0] OP_ADD = 8'h43;
  localparam logic [7:0] OP_SUB = 8'h44;
  localparam logic [7:0] OP_MUL = 8'h45;
  localparam logic [7:0] OP_DIV = 8'h46;
  localparam logic [7:0] OP_AND = 8'h47;
  localparam logic [7:0] OP_OR  = 8'h48;
  localparam logic [7:0] OP_CMP = 8'h49;
  localparam logic [7:0] OP_LW1 = 8'hA1;
  localparam logic [7:0] OP_LW  = 8'hC1;
  localparam logic [7:0] OP_SW  = 8'hC2;

  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count;

  // md_a: multiplicand (MUL) or dividend/quotient shift register (DIV)
  // md_b: multiplier (MUL) or divisor (DIV); md_acc: product or remainder
  logic [WIDTH-1:0]   md_a, md_b, md_acc;
  logic [WIDTH-1:0]   md_a_nx, md_b_nx, md_acc_nx;
  logic               md_div, md_rw;
  logic [3:0]         md_dest;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;

  logic               n_valid, n_rd, n_wr, n_rw, flag_upd, md_start;
  logic [WIDTH-1:0]   n_result, n_addr, n_store, diff;
  logic [3:0]         n_dest;

  assign stall_out = (state == BUSY);
  assign diff      = a_in - b_in;

  // One MUL or DIV iteration
  always_comb begin
    rem_sh = {md_acc, md_a[WIDTH-1]};
    div_ge = (rem_sh >= {1'b0, md_b});
    if (md_div) begin
      md_acc_nx = div_ge ? (rem_sh[WIDTH-1:0] - md_b) : rem_sh[WIDTH-1:0];
      md_a_nx   = {md_a[WIDTH-2:0], div_ge};
      md_b_nx   = md_b;
    end else begin
      md_acc_nx = md_acc + (md_b[0] ? md_a : '0);
      md_a_nx   = {md_a[WIDTH-2:0], 1'b0};
      md_b_nx   = {1'b0, md_b[WIDTH-1:1]};
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    n_valid  = 1'b0;
    n_result = '0;
    n_addr   = '0;
    n_store  = '0;
    n_rd     = 1'b0;
    n_wr     = 1'b0;
    n_dest   = '0;
    n_rw     = 1'b0;
    flag_upd = 1'b0;
    md_start = 1'b0;
    case (state)
      IDLE: if (valid_in) begin
        n_valid = 1'b1;
        n_dest  = destreg_in;
        n_rw    = set_regwrite_in;
        case (opcode_in)
          OP_ADD: n_result = a_in + b_in;
          OP_SUB: n_result = diff;
          OP_AND: n_result = a_in & b_in;
          OP_OR:  n_result = a_in | b_in;
          OP_NOT: n_result = ~a_in;
          OP_CMP: begin
            n_result = diff;
            n_rw     = 1'b0;
            flag_upd = 1'b1;
          end
          OP_LW: begin
            n_addr = b_in + imedi_in;
            n_rd   = 1'b1;
          end
          OP_LW1: begin
            n_addr = imedi_in;
            n_rd   = 1'b1;
          end
          OP_SW: begin
            n_addr  = b_in + imedi_in;
            n_store = a_in;
            n_wr    = 1'b1;
            n_rw    = 1'b0;
          end
          OP_MUL, OP_DIV: begin
            // Accept edge loads a bubble; the result arrives 16 edges later
            n_valid  = 1'b0;
            n_dest   = '0;
            n_rw     = 1'b0;
            md_start = 1'b1;
            state_nx = BUSY;
          end
          default: n_rw = 1'b0;
        endcase
      end
      BUSY: if (count == CNT_W'(1)) begin
        state_nx = IDLE;
        n_valid  = 1'b1;
        n_result = md_div ? md_a_nx : md_acc_nx;
        n_dest   = md_dest;
        n_rw     = md_rw;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      if (md_start)
        count <= CNT_W'(MD_CYCLES);
      else if (state == BUSY)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out        <= 1'b0;
      result_out       <= '0;
      addr_out         <= '0;
      store_data_out   <= '0;
      mem_read_out     <= 1'b0;
      mem_write_out    <= 1'b0;
      destreg_out      <= '0;
      set_regwrite_out <= 1'b0;
      flag_z           <= 1'b0;
      flag_n           <= 1'b0;
      flag_c           <= 1'b0;
    end else begin
      valid_out        <= n_valid;
      result_out       <= n_result;
      addr_out         <= n_addr;
      store_data_out   <= n_store;
      mem_read_out     <= n_rd;
      mem_write_out    <= n_wr;
      destreg_out      <= n_dest;
      set_regwrite_out <= n_rw;
      if (flag_upd) begin
        flag_z <= (a_in == b_in);
        flag_n <= diff[WIDTH-1];
        flag_c <= (a_in < b_in);
      end
    end
  end

  // NOTE: MUL/DIV working registers are deliberately not reset; they are
  // only observed in BUSY, which is always entered through a load.
  always_ff @(posedge clk) begin
    if (md_start) begin
      md_div  <= (opcode_in == OP_DIV);
      md_dest <= destreg_in;
      md_rw   <= set_regwrite_in;
      md_acc  <= '0;
      md_a    <= a_in;
      md_b    <= b_in;
    end else if (state == BUSY) begin
      md_acc  <= md_acc_nx;
      md_a    <= md_a_nx;
      md_b    <= md_b_nx;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table through a scoreboard queue,
// plus hand sequences for MUL/DIV stalls, flags, bubbles and mid-op reset.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [15:0] a_in, b_in, imedi_in;
  logic [7:0]  opcode_in;
  logic [3:0]  destreg_in;
  logic        set_regwrite_in;
  logic        stall_out, valid_out;
  logic [15:0] result_out, addr_out, store_data_out;
  logic        mem_read_out, mem_write_out;
  logic [3:0]  destreg_out;
  logic        set_regwrite_out, flag_z, flag_n, flag_c;

  ex_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
    .opcode_in(opcode_in), .imedi_in(imedi_in), .destreg_in(destreg_in),
    .set_regwrite_in(set_regwrite_in), .stall_out(stall_out),
    .valid_out(valid_out), .result_out(result_out), .addr_out(addr_out),
    .store_data_out(store_data_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .destreg_out(destreg_out),
    .set_regwrite_out(set_regwrite_out), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a, b, imm;
    logic [3:0]  dest;
    logic        rw;
    logic [15:0] e_res, e_addr, e_store;
    logic        e_rd, e_wr;
    logic        e_rw;
  } vec_t;

  typedef struct {
    logic [15:0] res, addr, store;
    logic        rd, wr;
    logic [3:0]  dest;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] imm, input logic [3:0] dest, input logic rw,
                     input logic [15:0] e_res, input logic [15:0] e_addr,
                     input logic [15:0] e_store, input logic e_rd, input logic e_wr,
                     input logic e_rw);
    exp_t e;
    valid_in = 1'b1; opcode_in = op; a_in = a; b_in = b; imedi_in = imm;
    destreg_in = dest; set_regwrite_in = rw;
    e.res = e_res; e.addr = e_addr; e.store = e_store; e.rd = e_rd; e.wr = e_wr;
    e.dest = dest; e.rw = e_rw;
    sb.push_back(e);
  endtask

  task automatic idle();
    valid_in = 1'b0; opcode_in = 8'h00; a_in = '0; b_in = '0; imedi_in = '0;
    destreg_in = '0; set_regwrite_in = 1'b0;
  endtask

  // Wait out a MUL/DIV with junk on the inputs; returns on the negedge where
  // stall_out has fallen, so the caller may present the next instruction.
  task automatic md_wait(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_out) break;
      cycles++;
      check("busy valid_out low", {31'd0, valid_out}, 32'd0);
      valid_in = 1'b1; opcode_in = 8'h43; a_in = 16'($urandom);
      b_in = 16'($urandom); destreg_in = 4'hF; set_regwrite_in = 1'b1;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      check("rd/wr exclusive", {31'd0, mem_read_out & mem_write_out}, 32'd0);
      if (valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected valid_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_out",       {16'd0, result_out},       {16'd0, e.res});
          check("addr_out",         {16'd0, addr_out},         {16'd0, e.addr});
          check("store_data_out",   {16'd0, store_data_out},   {16'd0, e.store});
          check("mem_read_out",     {31'd0, mem_read_out},     {31'd0, e.rd});
          check("mem_write_out",    {31'd0, mem_write_out},    {31'd0, e.wr});
          check("destreg_out",      {28'd0, destreg_out},      {28'd0, e.dest});
          check("set_regwrite_out", {31'd0, set_regwrite_out}, {31'd0, e.rw});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    int   cyc;

    //        op     a        b        imm      d  rw  res      addr     store    rd wr rw
    vt[0]  = '{8'h43, 16'h0005, 16'h0003, 16'h0000, 3, 1, 16'h0008, 16'h0000, 16'h0000, 0, 0, 1};
    vt[1]  = '{8'h44, 16'h0003, 16'h0005, 16'h0000, 4, 1, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 1};
    vt[2]  = '{8'h47, 16'hF0F0, 16'hFF00, 16'h0000, 5, 1, 16'hF000, 16'h0000, 16'h0000, 0, 0, 1};
    vt[3]  = '{8'h48, 16'hF0F0, 16'h0F00, 16'h0000, 6, 1, 16'hFFF0, 16'h0000, 16'h0000, 0, 0, 1};
    vt[4]  = '{8'h2A, 16'h1234, 16'h0000, 16'h0000, 7, 1, 16'hEDCB, 16'h0000, 16'h0000, 0, 0, 1};
    vt[5]  = '{8'h43, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1};
    vt[6]  = '{8'hC1, 16'h0000, 16'h0010, 16'h0040, 8, 1, 16'h0000, 16'h0050, 16'h0000, 1, 0, 1};
    vt[7]  = '{8'hC2, 16'hBEEF, 16'h0010, 16'h0040, 9, 1, 16'h0000, 16'h0050, 16'hBEEF, 0, 1, 0};
    vt[8]  = '{8'hA1, 16'h0000, 16'h0000, 16'h007B, 10, 1, 16'h0000, 16'h007B, 16'h0000, 1, 0, 1};
    vt[9]  = '{8'h0F, 16'h1111, 16'h2222, 16'h0000, 11, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0};
    vt[10] = '{8'h99, 16'h0001, 16'h0002, 16'h0000, 12, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0};
    vt[11] = '{8'h49, 16'h0002, 16'h0007, 16'h0000, 13, 1, 16'hFFFB, 16'h0000, 16'h0000, 0, 0, 0};

    idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset valid_out", {31'd0, valid_out}, 32'd0);
    check("reset stall_out", {31'd0, stall_out}, 32'd0);
    check("reset result/addr/store", {16'd0, result_out | addr_out | store_data_out}, 32'd0);
    check("reset ctl", {27'd0, mem_read_out, mem_write_out, set_regwrite_out,
                        destreg_out != 4'd0, 1'b0}, 32'd0);
    check("reset flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      put(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].dest, vt[i].rw,
          vt[i].e_res, vt[i].e_addr, vt[i].e_store, vt[i].e_rd, vt[i].e_wr, vt[i].e_rw);
    end
    @(negedge clk);
    idle();
    check("cmp 2-7 flags znc", {29'd0, flag_z, flag_n, flag_c}, 32'b011);

    @(negedge clk);
    put(8'h43, 16'h0001, 16'h0001, 16'h0000, 2, 1, 16'h0002, 0, 0, 0, 0, 1);
    @(negedge clk);
    idle();
    check("flags hold after add", {29'd0, flag_z, flag_n, flag_c}, 32'b011);
    @(negedge clk);
    check("bubble ctl", {28'd0, valid_out, mem_read_out, mem_write_out, set_regwrite_out}, 32'd0);

    put(8'h49, 16'h0005, 16'h0005, 16'h0000, 3, 1, 16'h0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    check("cmp equal flags znc", {29'd0, flag_z, flag_n, flag_c}, 32'b100);

    // MUL, then a back-to-back MUL 17 cycles later
    @(negedge clk);
    put(8'h45, 16'h0102, 16'h0003, 16'h0000, 4, 1, 16'h0306, 0, 0, 0, 0, 1);
    md_wait(cyc);
    check("mul stall cycles", cyc, 16);
    check("mul result valid", {31'd0, valid_out}, 32'd1);
    put(8'h45, 16'hFFFF, 16'h0002, 16'h0000, 5, 1, 16'hFFFE, 0, 0, 0, 0, 1);
    md_wait(cyc);
    check("mul2 stall cycles", cyc, 16);
    idle();

    @(negedge clk);
    put(8'h46, 16'h0064, 16'h0007, 16'h0000, 6, 1, 16'h000E, 0, 0, 0, 0, 1);
    md_wait(cyc);
    check("div stall cycles", cyc, 16);
    put(8'h46, 16'h1234, 16'h0000, 16'h0000, 7, 1, 16'hFFFF, 0, 0, 0, 0, 1);
    md_wait(cyc);
    check("div0 stall cycles", cyc, 16);
    put(8'h46, 16'hFFF0, 16'h0100, 16'h0000, 8, 0, 16'h00FF, 0, 0, 0, 0, 0);
    md_wait(cyc);
    check("div3 stall cycles", cyc, 16);
    idle();

    // Reset five cycles into a MUL aborts it
    @(negedge clk);
    put(8'h45, 16'h0003, 16'h0003, 16'h0000, 9, 1, 16'h0009, 0, 0, 0, 0, 1);
    repeat (5) @(negedge clk);
    idle();
    check("stall mid mul", {31'd0, stall_out}, 32'd1);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check("abort stall_out", {31'd0, stall_out}, 32'd0);
    check("abort valid_out", {31'd0, valid_out}, 32'd0);
    check("abort flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    reset = 1'b0;
    put(8'h43, 16'h0010, 16'h0020, 16'h0000, 2, 1, 16'h0030, 0, 0, 0, 0, 1);
    @(negedge clk);
    idle();
    check("add after abort valid", {31'd0, valid_out}, 32'd1);
    repeat (20) @(negedge clk);
    check("post-abort no late valid", {31'd0, valid_out}, 32'd0);
    check("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
